// File: rtl/dual_lane_flush_queue_pkg.sv
// Shared types and helpers for the dual-lane flush queue.
`include "defines.vh"

package dual_lane_flush_queue_pkg;

   localparam int ADDR_W = `ADDRESS_WIDTH;
   localparam int ID_W   = `ID_WIDTH;
   localparam int KILL_W = 8;

   // Round-robin priority holder: which lane wins when both heads are live.
   typedef enum logic {
      PRIO_LANE1 = 1'b0,
      PRIO_LANE2 = 1'b1
   } prio_e;

   // One buffered request; live=0 marks an entry killed by a flush.
   typedef struct packed {
      logic [ADDR_W-1:0] address;
      logic [ID_W-1:0]   id;
      logic              live;
   } entry_t;

   // Saturating accumulate for the kill counter.
   function automatic logic [KILL_W-1:0] sat_add(input logic [KILL_W-1:0] cur, input int add);
      int sum;
      sum = int'(cur) + add;
      if (sum > ((1 << KILL_W) - 1)) begin
         return '1;
      end
      return KILL_W'(sum);
   endfunction

endpackage

// File: rtl/defines.vh
// Shared bus widths for the dual-lane flush queue.
`ifndef DUAL_LANE_FLUSH_QUEUE_DEFINES_VH
`define DUAL_LANE_FLUSH_QUEUE_DEFINES_VH
`define ADDRESS_WIDTH 32
`define ID_WIDTH 8
`endif

// File: rtl/dual_lane_flush_queue_flush_fifo.sv
// One lane FIFO of {address, id, live}. A flush clears the live bit of every
// buffered entry carrying the flush tag; a push that matches the flush tag in
// the same cycle is written already dead. Dead entries still occupy a slot
// until the owner pops them.
module flush_fifo
   import dual_lane_flush_queue_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         push,
   input  logic [ADDR_W-1:0]            push_address,
   input  logic [ID_W-1:0]              push_id,
   input  logic                         pop,
   input  logic                         flush,
   input  logic [ID_W-1:0]              flush_id,
   output entry_t                       head,
   output logic                         empty,
   output logic                         full,
   output logic [$clog2(DEPTH):0]       kills
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   entry_t             mem_q [DEPTH];
   entry_t             mem_d [DEPTH];
   logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]   count_q, count_d;
   logic               push_eff;
   logic               pop_eff;
   logic               push_killed;
   logic [DEPTH-1:0]   slot_valid;
   logic [DEPTH-1:0]   slot_hit;

   assign empty       = (count_q == '0);
   assign full        = (count_q == CNT_W'(DEPTH));
   assign push_eff    = push && !full;
   assign pop_eff     = pop && !empty;
   assign push_killed = flush && (push_id == flush_id);
   assign head        = mem_q[rd_ptr_q];

   // Per-slot occupancy and flush match. The slot being popped this edge is
   // leaving the queue anyway, so it is never counted as a kill.
   for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
      logic [PTR_W-1:0] offset;
      assign offset         = PTR_W'(gi) - rd_ptr_q;
      assign slot_valid[gi] = ({1'b0, offset} < count_q);
      assign slot_hit[gi]   = flush && slot_valid[gi] && mem_q[gi].live &&
                              (mem_q[gi].id == flush_id) &&
                              !(pop_eff && (rd_ptr_q == PTR_W'(gi)));
   end

   // Next storage contents, pointer movement and number of entries killed.
   always_comb begin
      mem_d    = mem_q;
      kills    = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (slot_hit[i]) begin
            mem_d[i].live = 1'b0;
            kills         = kills + CNT_W'(1);
         end
      end
      if (push_eff) begin
         mem_d[wr_ptr_q].address = push_address;
         mem_d[wr_ptr_q].id      = push_id;
         mem_d[wr_ptr_q].live    = !push_killed;
         if (push_killed) begin
            kills = kills + CNT_W'(1);
         end
      end
      wr_ptr_d = wr_ptr_q + PTR_W'(push_eff);
      rd_ptr_d = rd_ptr_q + PTR_W'(pop_eff);
      count_d  = count_q + CNT_W'(push_eff) - CNT_W'(pop_eff);
   end

   // Storage and pointer registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= mem_d[i];
         end
      end
   end

endmodule

// File: rtl/dual_lane_flush_queue.sv
// Two request lanes, each buffered in a flushable FIFO, merged round-robin
// into a single registered output. Either lane filling up stalls both lanes.
module dual_lane_flush_queue
   import dual_lane_flush_queue_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [ADDR_W-1:0]    in_address_1,
   input  logic [ID_W-1:0]      in_id_1,
   input  logic                 in_valid_1,
   output logic                 out_stall_1,
   input  logic                 flush_1,
   input  logic [ID_W-1:0]      flush_id_1,
   input  logic [ADDR_W-1:0]    in_address_2,
   input  logic [ID_W-1:0]      in_id_2,
   input  logic                 in_valid_2,
   output logic                 out_stall_2,
   input  logic                 flush_2,
   input  logic [ID_W-1:0]      flush_id_2,
   output logic [ADDR_W-1:0]    mem_address,
   output logic [ID_W-1:0]      mem_id,
   output logic                 mem_lane,
   output logic                 mem_valid,
   input  logic                 mem_ready,
   output logic [KILL_W-1:0]    kill_count
);

   localparam int CNT_W = $clog2(DEPTH) + 1;

   entry_t              head_1, head_2;
   logic                empty_1, empty_2;
   logic                full_1, full_2;
   logic [CNT_W-1:0]    kills_1, kills_2;
   logic                stall;
   logic                push_1, push_2;
   logic                pop_1, pop_2;
   logic                live_head_1, live_head_2;
   logic                load;
   logic                grant_2;

   prio_e               prio_q, prio_d;
   logic [ADDR_W-1:0]   mem_address_q, mem_address_d;
   logic [ID_W-1:0]     mem_id_q, mem_id_d;
   logic                mem_lane_q, mem_lane_d;
   logic                mem_valid_q, mem_valid_d;
   logic [KILL_W-1:0]   kill_count_q, kill_count_d;

   // Occupancy comes from registered counters, so the stall never depends on
   // this cycle's pop: a full lane stays stalled until the pop has happened.
   assign stall       = full_1 || full_2;
   assign out_stall_1 = stall;
   assign out_stall_2 = stall;
   assign push_1      = in_valid_1 && !stall;
   assign push_2      = in_valid_2 && !stall;

   flush_fifo #(.DEPTH(DEPTH)) u_lane_1 (
      .clk          (clk),
      .reset        (reset),
      .push         (push_1),
      .push_address (in_address_1),
      .push_id      (in_id_1),
      .pop          (pop_1),
      .flush        (flush_1),
      .flush_id     (flush_id_1),
      .head         (head_1),
      .empty        (empty_1),
      .full         (full_1),
      .kills        (kills_1)
   );

   flush_fifo #(.DEPTH(DEPTH)) u_lane_2 (
      .clk          (clk),
      .reset        (reset),
      .push         (push_2),
      .push_address (in_address_2),
      .push_id      (in_id_2),
      .pop          (pop_2),
      .flush        (flush_2),
      .flush_id     (flush_id_2),
      .head         (head_2),
      .empty        (empty_2),
      .full         (full_2),
      .kills        (kills_2)
   );

   // Arbitration, pops, output register and kill counter next state.
   // Dead heads drain one per lane per cycle whether or not the output moves.
   always_comb begin
      live_head_1   = !empty_1 && head_1.live;
      live_head_2   = !empty_2 && head_2.live;
      load          = (!mem_valid_q || mem_ready) && (live_head_1 || live_head_2);
      grant_2       = live_head_2 && (!live_head_1 || (prio_q == PRIO_LANE2));
      pop_1         = (!empty_1 && !head_1.live) || (load && !grant_2);
      pop_2         = (!empty_2 && !head_2.live) || (load && grant_2);

      prio_d        = prio_q;
      mem_address_d = mem_address_q;
      mem_id_d      = mem_id_q;
      mem_lane_d    = mem_lane_q;
      mem_valid_d   = mem_valid_q;
      if (load) begin
         mem_valid_d   = 1'b1;
         mem_lane_d    = grant_2;
         mem_address_d = grant_2 ? head_2.address : head_1.address;
         mem_id_d      = grant_2 ? head_2.id : head_1.id;
         prio_d        = grant_2 ? PRIO_LANE1 : PRIO_LANE2;
      end else if (mem_ready) begin
         mem_valid_d = 1'b0;
      end

      kill_count_d = sat_add(kill_count_q, int'(kills_1) + int'(kills_2));
   end

   // Output register, priority state and kill counter.
   always_ff @(posedge clk) begin
      if (reset) begin
         prio_q        <= PRIO_LANE1;
         mem_address_q <= '0;
         mem_id_q      <= '0;
         mem_lane_q    <= 1'b0;
         mem_valid_q   <= 1'b0;
         kill_count_q  <= '0;
      end else begin
         prio_q        <= prio_d;
         mem_address_q <= mem_address_d;
         mem_id_q      <= mem_id_d;
         mem_lane_q    <= mem_lane_d;
         mem_valid_q   <= mem_valid_d;
         kill_count_q  <= kill_count_d;
      end
   end

   assign mem_address = mem_address_q;
   assign mem_id      = mem_id_q;
   assign mem_lane    = mem_lane_q;
   assign mem_valid   = mem_valid_q;
   assign kill_count  = kill_count_q;

endmodule

// File: tb/tb_dual_lane_flush_queue.sv
// Scoreboard bench for dual_lane_flush_queue (DEPTH=4).
module tb_dual_lane_flush_queue;
   import dual_lane_flush_queue_pkg::*;

   typedef struct packed {
      logic            lane;
      logic [ID_W-1:0] id;
   } exp_t;

   logic                clk = 1'b0;
   logic                reset = 1'b1;
   logic [ADDR_W-1:0]   in_address_1 = '0, in_address_2 = '0;
   logic [ID_W-1:0]     in_id_1 = '0, in_id_2 = '0;
   logic                in_valid_1 = 1'b0, in_valid_2 = 1'b0;
   logic                out_stall_1, out_stall_2;
   logic                flush_1 = 1'b0, flush_2 = 1'b0;
   logic [ID_W-1:0]     flush_id_1 = '0, flush_id_2 = '0;
   logic [ADDR_W-1:0]   mem_address;
   logic [ID_W-1:0]     mem_id;
   logic                mem_lane;
   logic                mem_valid;
   logic                mem_ready = 1'b0;
   logic [KILL_W-1:0]   kill_count;

   int   n_checks = 0;
   int   n_fail = 0;
   exp_t exp_q[$];

   dual_lane_flush_queue #(.DEPTH(4)) dut (
      .clk          (clk),
      .reset        (reset),
      .in_address_1 (in_address_1),
      .in_id_1      (in_id_1),
      .in_valid_1   (in_valid_1),
      .out_stall_1  (out_stall_1),
      .flush_1      (flush_1),
      .flush_id_1   (flush_id_1),
      .in_address_2 (in_address_2),
      .in_id_2      (in_id_2),
      .in_valid_2   (in_valid_2),
      .out_stall_2  (out_stall_2),
      .flush_2      (flush_2),
      .flush_id_2   (flush_id_2),
      .mem_address  (mem_address),
      .mem_id       (mem_id),
      .mem_lane     (mem_lane),
      .mem_valid    (mem_valid),
      .mem_ready    (mem_ready),
      .kill_count   (kill_count)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [ADDR_W-1:0] addr_of(input logic [ID_W-1:0] id);
      return ADDR_W'(32'h1000) + (ADDR_W'(id) << 2);
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_lane(input int lane, input logic v, input logic [ID_W-1:0] id);
      if (lane == 1) begin
         in_valid_1 = v; in_id_1 = id; in_address_1 = addr_of(id);
      end else begin
         in_valid_2 = v; in_id_2 = id; in_address_2 = addr_of(id);
      end
   endtask

   task automatic expect_out(input logic lane, input logic [ID_W-1:0] id);
      exp_q.push_back('{lane: lane, id: id});
   endtask

   task automatic do_reset();
      reset = 1'b1;
      mem_ready = 1'b0;
      set_lane(1, 1'b0, '0);
      set_lane(2, 1'b0, '0);
      flush_1 = 1'b0; flush_2 = 1'b0;
      repeat (2) tick();
      reset = 1'b0;
   endtask

   task automatic wait_drain(input int budget);
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < budget) begin
         tick();
         n++;
      end
      check_eq("drain_remaining", 64'(exp_q.size()), 64'd0);
   endtask

   // Output monitor: one line per accepted transaction, compared to the scoreboard.
   always @(negedge clk) begin
      if (!reset && mem_valid && mem_ready) begin
         $display("out lane=%0d id=%02h addr=%08h", mem_lane, mem_id, mem_address);
         check_eq("sb_has_entry", 64'(exp_q.size() != 0), 64'd1);
         if (exp_q.size() != 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check_eq("out_id", 64'(mem_id), 64'(e.id));
            check_eq("out_lane", 64'(mem_lane), 64'(e.lane));
            check_eq("out_addr", 64'(mem_address), 64'(addr_of(e.id)));
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation exceeded time budget");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset state
      do_reset();
      check_eq("rst_mem_valid", 64'(mem_valid), 64'd0);
      check_eq("rst_mem_id", 64'(mem_id), 64'd0);
      check_eq("rst_mem_address", 64'(mem_address), 64'd0);
      check_eq("rst_mem_lane", 64'(mem_lane), 64'd0);
      check_eq("rst_kill_count", 64'(kill_count), 64'd0);
      check_eq("rst_stall", 64'({out_stall_1, out_stall_2}), 64'd0);

      // Single-lane order and 2-edge latency
      mem_ready = 1'b1;
      set_lane(1, 1'b1, 8'h11); expect_out(1'b0, 8'h11);
      tick();
      set_lane(1, 1'b0, '0);
      check_eq("latency_t_plus_0", 64'(mem_valid), 64'd0);
      tick();
      check_eq("latency_t_plus_1", 64'(mem_valid), 64'd1);
      for (int k = 2; k <= 4; k++) begin
         set_lane(1, 1'b1, ID_W'(8'h10 + k)); expect_out(1'b0, ID_W'(8'h10 + k));
         tick();
      end
      set_lane(1, 1'b0, '0);
      wait_drain(20);

      // Round-robin between two busy lanes
      do_reset();
      mem_ready = 1'b1;
      set_lane(1, 1'b1, 8'h11); set_lane(2, 1'b1, 8'h21);
      expect_out(1'b0, 8'h11); expect_out(1'b1, 8'h21);
      tick();
      set_lane(1, 1'b1, 8'h12); set_lane(2, 1'b1, 8'h22);
      expect_out(1'b0, 8'h12); expect_out(1'b1, 8'h22);
      tick();
      set_lane(1, 1'b0, '0); set_lane(2, 1'b0, '0);
      wait_drain(20);

      // Fill lane 1 while output is blocked, kill a buffered entry, release
      do_reset();
      expect_out(1'b0, 8'h15); expect_out(1'b0, 8'h17);
      expect_out(1'b0, 8'h18); expect_out(1'b0, 8'h19);
      for (int k = 0; k < 5; k++) begin
         set_lane(1, 1'b1, ID_W'(8'h15 + k));
         tick();
      end
      set_lane(1, 1'b0, '0);
      check_eq("full_stall_1", 64'(out_stall_1), 64'd1);
      check_eq("full_stall_2", 64'(out_stall_2), 64'd1);
      set_lane(2, 1'b1, 8'h2A);
      repeat (2) tick();
      set_lane(2, 1'b0, '0);
      check_eq("hold_mem_id", 64'(mem_id), 64'h15);
      check_eq("hold_mem_valid", 64'(mem_valid), 64'd1);
      flush_1 = 1'b1; flush_id_1 = 8'h16;
      tick();
      flush_1 = 1'b0;
      check_eq("stalled_kill_count", 64'(kill_count), 64'd1);
      check_eq("stall_after_flush", 64'(out_stall_1), 64'd1);
      mem_ready = 1'b1;
      tick();
      check_eq("stall_drop_after_pop", 64'({out_stall_1, out_stall_2}), 64'd0);
      wait_drain(20);

      // Flush on the same edge as the matching push
      do_reset();
      mem_ready = 1'b1;
      set_lane(1, 1'b1, 8'h12); expect_out(1'b0, 8'h12);
      tick();
      set_lane(1, 1'b1, 8'h13);
      flush_1 = 1'b1; flush_id_1 = 8'h13;
      tick();
      flush_1 = 1'b0;
      set_lane(1, 1'b1, 8'h14); expect_out(1'b0, 8'h14);
      tick();
      set_lane(1, 1'b0, '0);
      wait_drain(20);
      check_eq("push_flush_kill_count", 64'(kill_count), 64'd1);

      // Simultaneous kills on both lanes add, and the counter saturates
      do_reset();
      mem_ready = 1'b1;
      set_lane(1, 1'b1, 8'h40); set_lane(2, 1'b1, 8'h40);
      flush_1 = 1'b1; flush_id_1 = 8'h40;
      flush_2 = 1'b1; flush_id_2 = 8'h40;
      tick();
      check_eq("dual_kill_sum", 64'(kill_count), 64'd2);
      repeat (126) tick();
      check_eq("kill_count_254", 64'(kill_count), 64'd254);
      repeat (2) tick();
      check_eq("kill_count_sat", 64'(kill_count), 64'd255);
      set_lane(1, 1'b0, '0); set_lane(2, 1'b0, '0);
      flush_1 = 1'b0; flush_2 = 1'b0;
      repeat (4) tick();

      // Reset mid-operation discards everything
      do_reset();
      set_lane(1, 1'b1, 8'h51); set_lane(2, 1'b1, 8'h61);
      tick();
      set_lane(1, 1'b1, 8'h52); set_lane(2, 1'b1, 8'h62);
      tick();
      set_lane(1, 1'b0, '0); set_lane(2, 1'b0, '0);
      tick();
      check_eq("pre_reset_mem_valid", 64'(mem_valid), 64'd1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check_eq("mid_rst_mem_valid", 64'(mem_valid), 64'd0);
      check_eq("mid_rst_mem_id", 64'(mem_id), 64'd0);
      check_eq("mid_rst_mem_address", 64'(mem_address), 64'd0);
      check_eq("mid_rst_mem_lane", 64'(mem_lane), 64'd0);
      check_eq("mid_rst_kill_count", 64'(kill_count), 64'd0);
      check_eq("mid_rst_stall", 64'({out_stall_1, out_stall_2}), 64'd0);
      mem_ready = 1'b1;
      repeat (8) tick();
      set_lane(2, 1'b1, 8'h63); expect_out(1'b1, 8'h63);
      tick();
      set_lane(2, 1'b0, '0);
      wait_drain(20);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
